dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-cycle core's data memory between the core's load/store path and a debug/loader port, used for program loading, memory inspection and DMA-style fills. Sits between the core's ALU-result and store-data signals and the `data_memory` instance. The core normally has priority. A starvation counter guarantees debug progress. A halt FSM can freeze the core for bulk transfers. Losing core accesses are stalled through `core_stall`, which gates the PC update and `RegWrite`.

## Interface
- `DATA_W`, 32, data width
- `ADDR_W`, 32, byte address width
- `STARVE_LIMIT`, 4, maximum consecutive cycles a pending debug request may lose to the core (0 = debug always wins)
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `core_mem_read` in 1: core load this cycle
- `core_mem_write` in 1: core store this cycle
- `core_addr` in ADDR_W: ALU result address
- `core_wdata` in DATA_W: store data
- `core_rdata` out DATA_W: load data to write-back mux
- `core_stall` out 1: hold PC and suppress RegWrite this cycle
- `core_halted` out 1: core frozen by debug
- `dbg_halt` in 1: level request to freeze core
- `dbg_valid` in 1, `dbg_ready` out 1: request handshake
- `dbg_we` in 1, `dbg_addr` in ADDR_W, `dbg_wdata` in DATA_W: request payload
- `dbg_rvalid` out 1, `dbg_rdata` out DATA_W: read response
- `mem_write` out 1, `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: to `data_memory`
- `mem_rdata` in DATA_W: combinational read from `data_memory`

## Operation
- **Halt FSM states:** RUN and HALTED.
  - RUN→HALTED at the edge where `dbg_halt`=1.
  - HALTED→RUN at the edge where `dbg_halt`=0 and `dbg_rvalid`=0.
  - `core_halted`=1 only in HALTED.
- **Grant:** `dbg_gnt = dbg_valid & (state==HALTED | ~(core_mem_read|core_mem_write) | wait_cnt==STARVE_LIMIT)`. `dbg_ready` = `dbg_gnt`, combinational.
- **Stall:** `core_stall = (state==HALTED) | (dbg_gnt & (core_mem_read|core_mem_write))`.
- **Memory mux:**
  - On `dbg_gnt`, the memory is driven from the dbg port: `mem_write=dbg_we`.
  - Otherwise the core drives it: `mem_write = core_mem_write & ~core_stall`.
  - A stalled core store is never committed; it replays next cycle.
- `core_rdata` = `mem_rdata`, always. Its value is don't-care while stalled.
- **wait_cnt:**
  - Increments when `dbg_valid & ~dbg_ready`.
  - Clears on grant or when `dbg_valid`=0.
  - Saturates at STARVE_LIMIT. Width is `$clog2(STARVE_LIMIT+1)`, minimum 1.
- **Read response:** on a granted read (`dbg_we`=0), `dbg_rdata` <= `mem_rdata` and `dbg_rvalid` <= 1. `dbg_rvalid` is otherwise 0, a one-cycle pulse.
- **Debug port rules:** `dbg_valid` and its payload must stay stable until `dbg_ready`. Back-to-back requests are allowed, one per cycle.
- `dbg_halt` and `dbg_valid` in the same cycle: the grant follows the current state, and the halt takes effect at the edge.

## Timing
- **Reset values:** state=RUN, wait_cnt=0, `dbg_rvalid`=0, `dbg_rdata`=0, stats=0. Combinational outputs follow from these: `core_stall`=0, `core_halted`=0, `dbg_ready`=`dbg_valid & core idle`.
- **Latency:**
  - A debug write commits at the edge closing its grant cycle.
  - A debug read returns data the following cycle.
  - A core access has zero added latency unless stalled.
- **Worst-case debug wait:** STARVE_LIMIT cycles, granted on the cycle where wait_cnt==STARVE_LIMIT.
- **HALTED entry:** `core_stall` asserts the cycle after `dbg_halt` is first sampled.
- **Reset asserted mid-transaction:** a pending `dbg_rvalid` is dropped, and no memory write happens in the reset cycle (`mem_write` forced 0 while `rst`).

## Configuration
- `DMEM_ARB_STATS_EN` defined adds two outputs:
  - `stat_dbg_grants` (32): counts `dbg_gnt` cycles.
  - `stat_core_stalls` (32): counts `core_stall` cycles.
  - Both wrap at 2^32 and clear on `rst`.
- When the macro is undefined, the ports and counters are absent and the behaviour is otherwise identical.

## Structure
- The shared package `dmem_arb_pkg` holds the state enum `arb_state_t` (RUN, HALTED) and the default constants `DMEM_ARB_STARVE_LIMIT_DEF`=4 and `DMEM_ARB_DATA_W_DEF`=32.
- Sub-module `arb_wait_counter` contains the saturating starvation counter, with parameter LIMIT and ports clk, rst, inc, clr, at_limit.

## Test plan
- **Idle core:** with core idle, dbg write 0xDEADBEEF to 0x10, then read 0x10 → `dbg_ready`=1 in the same cycle and `dbg_rvalid`=1 one cycle later with `dbg_rdata`=0xDEADBEEF. `core_stall` stays 0.
- **Starvation limit:** with the core loading every cycle and `dbg_valid` held (STARVE_LIMIT=4) → `dbg_ready` asserts on the 5th cycle with `core_stall`=1 that cycle only, and the core load completes the next cycle.
- **Colliding store:** core store of 0x1111 to 0x20 in the same cycle as a granted dbg write of 0x2222 to 0x20 → memory holds 0x2222 after the grant edge and 0x1111 after the core replay.
- **Halt:** assert `dbg_halt` → `core_halted`=1 and `core_stall`=1 from the next cycle. Issue 8 back-to-back dbg writes → 8 commits in 8 cycles. Drop `dbg_halt` while a read response is pending → RUN is entered only after `dbg_rvalid` is seen.
- **Reset mid-read:** `rst` asserted in the cycle after a dbg read grant → `dbg_rvalid`=0, state=RUN, no `mem_write`. The stats counters (with `DMEM_ARB_STATS_EN`) read 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg : shared types and defaults for the data-memory arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dmem_arb_pkg;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } arb_state_t;

  localparam int DMEM_ARB_STARVE_LIMIT_DEF = 4;
  localparam int DMEM_ARB_DATA_W_DEF       = 32;

  // A limit of 0 still needs a 1-bit counter so the compare is well formed.
  function automatic int arb_cnt_width(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_wait_counter.sv
// ----------------------------------------------------------------------------
// arb_wait_counter : saturating count of cycles a debug request has lost
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module arb_wait_counter
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = DMEM_ARB_STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int             CNT_W   = arb_cnt_width(LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign at_limit = (cnt_q == LIMIT_C);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_limit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter : shares data memory between the core and a debug/loader port
// Optional statistics outputs enabled by DMEM_ARB_STATS_EN.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W       = DMEM_ARB_DATA_W_DEF,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = DMEM_ARB_STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_mem_read,
  input  logic              core_mem_write,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  output logic              core_halted,
  input  logic              dbg_halt,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_dbg_grants,
  output logic [31:0]       stat_core_stalls
`endif
);

  arb_state_t        state_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              core_req;
  logic              at_limit;
  logic              dbg_gnt;
  logic              halted;

  assign core_req = core_mem_read | core_mem_write;
  assign halted   = (state_q == HALTED);
  assign dbg_gnt  = dbg_valid & (halted | ~core_req | at_limit);

  assign dbg_ready   = dbg_gnt;
  assign core_stall  = halted | (dbg_gnt & core_req);
  assign core_halted = halted;
  assign core_rdata  = mem_rdata;
  assign dbg_rvalid  = rvalid_q;
  assign dbg_rdata   = rdata_q;

  // A stalled core store is dropped here and replays once the stall lifts.
  assign mem_write = rst ? 1'b0 : (dbg_gnt ? dbg_we : (core_mem_write & ~core_stall));
  assign mem_addr  = dbg_gnt ? dbg_addr  : core_addr;
  assign mem_wdata = dbg_gnt ? dbg_wdata : core_wdata;

  arb_wait_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (dbg_valid & ~dbg_gnt),
    .clr      (dbg_gnt | ~dbg_valid),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        RUN:     if (dbg_halt) state_q <= HALTED;
        // Leaving HALTED waits for an outstanding read response to drain.
        HALTED:  if (!dbg_halt && !rvalid_q) state_q <= RUN;
        default: state_q <= RUN;
      endcase
      rvalid_q <= dbg_gnt & ~dbg_we;
      if (dbg_gnt && !dbg_we) begin
        rdata_q <= mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] grants_q;
  logic [31:0] stalls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else begin
      grants_q <= grants_q + {31'd0, dbg_gnt};
      stalls_q <= stalls_q + {31'd0, core_stall};
    end
  end

  assign stat_dbg_grants  = grants_q;
  assign stat_core_stalls = stalls_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter : table-driven check of dmem_arbiter with a small memory
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_mem_read, core_mem_write;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_stall, core_halted;
  logic        dbg_halt, dbg_valid, dbg_ready, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_dbg_grants, stat_core_stalls;
`endif

  logic [31:0] mem [0:63];
  int n_vec  = 0;
  int n_fail = 0;
  int cur    = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

  dmem_arbiter #(
    .DATA_W       (32),
    .ADDR_W       (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .core_mem_read  (core_mem_read),
    .core_mem_write (core_mem_write),
    .core_addr      (core_addr),
    .core_wdata     (core_wdata),
    .core_rdata     (core_rdata),
    .core_stall     (core_stall),
    .core_halted    (core_halted),
    .dbg_halt       (dbg_halt),
    .dbg_valid      (dbg_valid),
    .dbg_ready      (dbg_ready),
    .dbg_we         (dbg_we),
    .dbg_addr       (dbg_addr),
    .dbg_wdata      (dbg_wdata),
    .dbg_rvalid     (dbg_rvalid),
    .dbg_rdata      (dbg_rdata),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_dbg_grants  (stat_dbg_grants),
    .stat_core_stalls (stat_core_stalls)
`endif
  );

  typedef struct {
    logic        rst, halt, crd, cwr;
    logic [31:0] ca, cwd;
    logic        dv, dwe;
    logic [31:0] da, dwd;
    logic        e_rdy, e_stall, e_halted, e_mwr;
    logic [31:0] e_maddr;
    logic        e_rvalid;
    logic [31:0] e_rdata;
    logic        chk_crd;
    logic [31:0] e_crdata;
  } vec_t;

  vec_t tbl [0:63];
  int   n_tbl = 0;

  function automatic vec_t mk(
    input logic r, h, crd, cwr, input logic [31:0] ca, cwd,
    input logic dv, dwe, input logic [31:0] da, dwd,
    input logic rdy, st, hl, mw, input logic [31:0] ma,
    input logic rv, input logic [31:0] rd, input logic ck, input logic [31:0] cr);
    vec_t v;
    v.rst = r; v.halt = h; v.crd = crd; v.cwr = cwr; v.ca = ca; v.cwd = cwd;
    v.dv = dv; v.dwe = dwe; v.da = da; v.dwd = dwd;
    v.e_rdy = rdy; v.e_stall = st; v.e_halted = hl; v.e_mwr = mw; v.e_maddr = ma;
    v.e_rvalid = rv; v.e_rdata = rd; v.chk_crd = ck; v.e_crdata = cr;
    return v;
  endfunction

  task automatic add(input vec_t v);
    tbl[n_tbl] = v;
    n_tbl++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [vec %0d]: got 0x%0h, want 0x%0h", nm, cur, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; dbg_halt = v.halt; core_mem_read = v.crd; core_mem_write = v.cwr;
    core_addr = v.ca; core_wdata = v.cwd; dbg_valid = v.dv; dbg_we = v.dwe;
    dbg_addr = v.da; dbg_wdata = v.dwd;
    #3;
    chk("dbg_ready",   32'(dbg_ready),   32'(v.e_rdy));
    chk("core_stall",  32'(core_stall),  32'(v.e_stall));
    chk("core_halted", 32'(core_halted), 32'(v.e_halted));
    chk("mem_write",   32'(mem_write),   32'(v.e_mwr));
    chk("mem_addr",    mem_addr,         v.e_maddr);
    chk("dbg_rvalid",  32'(dbg_rvalid),  32'(v.e_rvalid));
    chk("dbg_rdata",   dbg_rdata,        v.e_rdata);
    if (v.chk_crd) chk("core_rdata", core_rdata, v.e_crdata);
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst = 1'b1; dbg_halt = 1'b0; core_mem_read = 1'b0; core_mem_write = 1'b0;
    core_addr = '0; core_wdata = '0; dbg_valid = 1'b0; dbg_we = 1'b0;
    dbg_addr = '0; dbg_wdata = '0;

    // reset state, then idle-core debug write/read
    add(mk('0,'0,'0,'0, 32'h0,32'h0, '0,'0, 32'h0,32'h0,        '0,'0,'0,'0, 32'h0,  '0,32'h0, '0,32'h0));
    add(mk('0,'0,'0,'0, 32'h0,32'h0, '1,'1, 32'h10,DB,          '1,'0,'0,'1, 32'h10, '0,32'h0, '0,32'h0));
    add(mk('0,'0,'0,'0, 32'h0,32'h0, '1,'0, 32'h10,32'h0,       '1,'0,'0,'0, 32'h10, '0,32'h0, '1,DB));
    add(mk('0,'0,'0,'0, 32'h0,32'h0, '0,'0, 32'h0,32'h0,        '0,'0,'0,'0, 32'h0,  '1,DB,    '0,32'h0));
    add(mk('0,'0,'0,'0, 32'h0,32'h0, '0,'0, 32'h0,32'h0,        '0,'0,'0,'0, 32'h0,  '0,DB,    '0,32'h0));
    // starvation: core loads every cycle, debug write wins on the 5th cycle
    for (int k = 0; k < 4; k++)
      add(mk('0,'0,'1,'0, 32'h10,32'h0, '1,'1, 32'h40,32'hA5A5, '0,'0,'0,'0, 32'h10, '0,DB, '1,DB));
    add(mk('0,'0,'1,'0, 32'h10,32'h0, '1,'1, 32'h40,32'hA5A5,   '1,'1,'0,'1, 32'h40, '0,DB, '0,32'h0));
    add(mk('0,'0,'1,'0, 32'h10,32'h0, '0,'0, 32'h0,32'h0,       '0,'0,'0,'0, 32'h10, '0,DB, '1,DB));
    // colliding store: debug 0x2222 wins, core 0x1111 replays afterwards
    for (int k = 0; k < 4; k++)
      add(mk('0,'0,'0,'1, 32'h20,32'h1111, '1,'1, 32'h20,32'h2222, '0,'0,'0,'1, 32'h20, '0,DB, '0,32'h0));
    add(mk('0,'0,'0,'1, 32'h20,32'h1111, '1,'1, 32'h20,32'h2222,   '1,'1,'0,'1, 32'h20, '0,DB, '0,32'h0));
    add(mk('0,'0,'0,'1, 32'h20,32'h1111, '0,'0, 32'h0,32'h0,       '0,'0,'0,'1, 32'h20, '0,DB, '1,32'h2222));
    add(mk('0,'0,'1,'0, 32'h20,32'h0,    '0,'0, 32'h0,32'h0,       '0,'0,'0,'0, 32'h20, '0,DB, '1,32'h1111));
    add(mk('0,'0,'0,'0, 32'h0,32'h0,     '0,'0, 32'h0,32'h0,       '0,'0,'0,'0, 32'h0,  '0,DB, '0,32'h0));
    // halt entry; core store while halted must not reach memory
    add(mk('0,'1,'0,'0, 32'h0,32'h0,     '0,'0, 32'h0,32'h0,       '0,'0,'0,'0, 32'h0,  '0,DB, '0,32'h0));
    add(mk('0,'1,'0,'1, 32'h30,32'h9999, '0,'0, 32'h0,32'h0,       '0,'1,'1,'0, 32'h30, '0,DB, '0,32'h0));
    for (int i = 0; i < 8; i++)
      add(mk('0,'1,'0,'0, 32'h0,32'h0, '1,'1, 32'h80 + 32'(4*i), 32'h100 + 32'(i),
             '1,'1,'1,'1, 32'h80 + 32'(4*i), '0,DB, '0,32'h0));
    // drop halt while a read response is pending
    add(mk('0,'1,'0,'0, 32'h0,32'h0, '1,'0, 32'h84,32'h0, '1,'1,'1,'0, 32'h84, '0,DB,      '1,32'h101));
    add(mk('0,'0,'0,'0, 32'h0,32'h0, '0,'0, 32'h0,32'h0,  '0,'1,'1,'0, 32'h0,  '1,32'h101, '0,32'h0));
    add(mk('0,'0,'0,'0, 32'h0,32'h0, '0,'0, 32'h0,32'h0,  '0,'1,'1,'0, 32'h0,  '0,32'h101, '0,32'h0));
    add(mk('0,'0,'0,'0, 32'h0,32'h0, '0,'0, 32'h0,32'h0,  '0,'0,'0,'0, 32'h0,  '0,32'h101, '0,32'h0));
    // reset in the cycle after a halted debug read grant
    add(mk('0,'1,'0,'0, 32'h0,32'h0, '0,'0, 32'h0,32'h0,  '0,'0,'0,'0, 32'h0,  '0,32'h101, '0,32'h0));
    add(mk('0,'1,'0,'0, 32'h0,32'h0, '1,'0, 32'h10,32'h0, '1,'1,'1,'0, 32'h10, '0,32'h101, '1,DB));
    add(mk('1,'1,'0,'0, 32'h0,32'h0, '1,'1, 32'h10,32'hBAD, '1,'1,'1,'0, 32'h10, '1,DB,    '0,32'h0));
    add(mk('0,'0,'0,'0, 32'h0,32'h0, '0,'0, 32'h0,32'h0,  '0,'0,'0,'0, 32'h0,  '0,32'h0,   '0,32'h0));

    repeat (2) @(negedge clk);
    for (int i = 0; i < n_tbl; i++) begin
      cur = i;
      apply(tbl[i]);
    end

    cur = n_tbl;
    chk("mem[0x10]", mem[4],  DB);
    chk("mem[0x20]", mem[8],  32'h1111);
    chk("mem[0x30]", mem[12], 32'h0);
    chk("mem[0x40]", mem[16], 32'hA5A5);
    for (int i = 0; i < 8; i++) chk("burst_mem", mem[32 + i], 32'h100 + 32'(i));
`ifdef DMEM_ARB_STATS_EN
    chk("stat_dbg_grants",  stat_dbg_grants,  32'h0);
    chk("stat_core_stalls", stat_core_stalls, 32'h0);
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
